// File: rtl/count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_event_monitor
// Brief    : Classifies counter transitions (WRAP/MATCH/JUMP) into an event
//            FIFO, with a saturating wrap tally and a stretched match pulse.
//            Optional macro EVT_STAMP_EN adds 8-bit timestamps to each event.
// Revision : 1.0 - initial release
// ============================================================================
module count_event_monitor #(
    parameter int WIDTH     = 4,
    parameter int EVT_DEPTH = 4,
    parameter int STRETCH   = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_mode,
    input  logic             arm,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [7:0]       evt_stamp,
    output logic [7:0]       wrap_cnt,
    output logic             match_pulse,
    output logic             fifo_full,
    output logic             overflow
);

    localparam int         c_PTR_W   = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int         c_CNT_W   = c_PTR_W + 1;
    localparam int         c_HOLD_W  = (STRETCH > 1) ? $clog2(STRETCH) : 1;
`ifdef EVT_STAMP_EN
    localparam int         c_ENTRY_W = 10;
`else
    localparam int         c_ENTRY_W = 2;
`endif
    localparam logic [WIDTH-1:0]    c_MAX       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]    c_ZERO      = '0;
    localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(EVT_DEPTH);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(STRETCH - 1);
    localparam logic [1:0]          c_EVT_WRAP  = 2'b00;
    localparam logic [1:0]          c_EVT_MATCH = 2'b01;
    localparam logic [1:0]          c_EVT_JUMP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sampling pipeline
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_prev;
    logic             r_mode;
    logic             r_cur_valid;
    logic             r_prev_valid;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_cur        <= '0;
            r_prev       <= '0;
            r_mode       <= 1'b0;
            r_cur_valid  <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_cur        <= cnt_in;
            r_mode       <= cnt_mode;
            r_prev       <= r_cur;
            r_cur_valid  <= 1'b1;
            r_prev_valid <= r_cur_valid;
        end
    end

    // ------------------------------------------------------------------
    // Transition classification
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_step;
    logic             w_changed;
    logic             w_wrap;
    logic             w_jump;
    logic             w_match;
    logic             w_push;
    logic [1:0]       w_code;

    assign w_step    = r_mode ? (r_prev + 1'b1) : (r_prev - 1'b1);
    assign w_changed = (r_prev != r_cur);
    assign w_wrap    = r_prev_valid &&
                       (r_mode ? ((r_prev == c_MAX)  && (r_cur == c_ZERO))
                               : ((r_prev == c_ZERO) && (r_cur == c_MAX)));
    assign w_jump    = r_prev_valid && w_changed && (r_cur != w_step);
    assign w_match   = r_prev_valid && arm && w_changed && (r_cur == cmp_val);

    always_comb begin
        w_push = 1'b0;
        w_code = c_EVT_WRAP;
        if (w_wrap) begin
            w_push = 1'b1;
            w_code = c_EVT_WRAP;
        end else if (w_match) begin
            w_push = 1'b1;
            w_code = c_EVT_MATCH;
        end else if (w_jump) begin
            w_push = 1'b1;
            w_code = c_EVT_JUMP;
        end
    end

    // ------------------------------------------------------------------
    // Optional timestamp counter and FIFO entry packing
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;

`ifdef EVT_STAMP_EN
    logic [7:0] r_stamp;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_stamp <= 8'd0;
        end else begin
            r_stamp <= r_stamp + 8'd1;
        end
    end

    assign w_entry   = {r_stamp, w_code};
    assign evt_stamp = evt_valid ? w_head[9:2] : 8'd0;
`else
    assign w_entry   = w_code;
    assign evt_stamp = 8'd0;
`endif

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [EVT_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_wr;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && evt_ready;
    // A pop frees the slot in the same edge, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign evt_valid = !w_empty;
    assign evt_code  = evt_valid ? w_head[1:0] : 2'b00;
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

    // ------------------------------------------------------------------
    // Saturating wrap tally (counts every WRAP, queued or dropped)
    // ------------------------------------------------------------------
    logic [7:0] r_wrap_cnt;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wrap_cnt <= 8'd0;
        end else if (w_wrap && (r_wrap_cnt != 8'hFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
        end
    end

    assign wrap_cnt = r_wrap_cnt;

    // ------------------------------------------------------------------
    // Match pulse stretcher
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_match) begin
                    w_state_nxt = S_HOLD;
                    w_hold_nxt  = c_HOLD_LOAD;
                end else if (!arm) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                // Further matches and arm changes are ignored until expiry.
                if (r_hold == '0) begin
                    w_state_nxt = arm ? S_ARMED : S_IDLE;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign match_pulse = (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_event_monitor
// Brief    : Directed self-checking bench for count_event_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_event_monitor;

    logic       clk;
    logic       rstn;
    logic [3:0] cnt_in;
    logic       cnt_mode;
    logic       arm;
    logic [3:0] cmp_val;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic [7:0] evt_stamp;
    logic [7:0] wrap_cnt;
    logic       match_pulse;
    logic       fifo_full;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    count_event_monitor #(
        .WIDTH     (4),
        .EVT_DEPTH (4),
        .STRETCH   (3)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cnt_in      (cnt_in),
        .cnt_mode    (cnt_mode),
        .arm         (arm),
        .cmp_val     (cmp_val),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_stamp   (evt_stamp),
        .wrap_cnt    (wrap_cnt),
        .match_pulse (match_pulse),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, evt_valid, 0);
        chk({tag, "_code"},  evt_code, 0);
        chk({tag, "_stamp"}, evt_stamp, 0);
        chk({tag, "_wrap"},  wrap_cnt, 0);
        chk({tag, "_pulse"}, match_pulse, 0);
        chk({tag, "_full"},  fifo_full, 0);
        chk({tag, "_ovf"},   overflow, 0);
    endtask

    // Leaves reset released, #1 after an edge; the next edge is the first sample.
    task automatic do_reset();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
    endtask

    initial begin
        rstn      = 1'b1;
        cnt_in    = 4'd0;
        cnt_mode  = 1'b1;
        arm       = 1'b0;
        cmp_val   = 4'd0;
        evt_ready = 1'b1;
        tick();
        tick();
        chk_all_zero("rst");

        // Up-count wrap 13,14,15,0,1
        cnt_in = 4'd13; rstn = 1'b0;
        tick();
        cnt_in = 4'd14; tick();
        cnt_in = 4'd15; tick();
        chk("t1_none_a", evt_valid, 0);
        cnt_in = 4'd0;  tick();
        chk("t1_none_b", evt_valid, 0);
        cnt_in = 4'd1;  tick();
        chk("t1_valid", evt_valid, 1);
        chk("t1_code", evt_code, 2'b00);
        chk("t1_wrap", wrap_cnt, 1);
`ifdef EVT_STAMP_EN
        chk("t1_stamp", evt_stamp, 4);
`else
        chk("t1_stamp", evt_stamp, 0);
`endif
        tick();
        chk("t1_popped", evt_valid, 0);
        tick();
        chk("t1_quiet", evt_valid, 0);
        chk("t1_wrap_hold", wrap_cnt, 1);

        // Down-count wrap then a load jump 15 -> 7
        cnt_mode = 1'b0;
        do_reset();
        cnt_in = 4'd2;  tick();
        cnt_in = 4'd1;  tick();
        cnt_in = 4'd0;  tick();
        cnt_in = 4'd15; tick();
        chk("t2_none", evt_valid, 0);
        cnt_in = 4'd7;  tick();
        chk("t2_wrap_valid", evt_valid, 1);
        chk("t2_wrap_code", evt_code, 2'b00);
        chk("t2_wrap_cnt", wrap_cnt, 1);
        tick();
        chk("t2_jump_valid", evt_valid, 1);
        chk("t2_jump_code", evt_code, 2'b10);
        tick();
        chk("t2_empty", evt_valid, 0);

        // Armed match on 5 with a 3-cycle stretched pulse
        cnt_mode = 1'b1; arm = 1'b1; cmp_val = 4'd5;
        do_reset();
        cnt_in = 4'd3; tick();
        cnt_in = 4'd4; tick();
        cnt_in = 4'd5; tick();
        chk("t3_pulse_pre", match_pulse, 0);
        chk("t3_none", evt_valid, 0);
        cnt_in = 4'd6; tick();
        chk("t3_valid", evt_valid, 1);
        chk("t3_code", evt_code, 2'b01);
        chk("t3_pulse1", match_pulse, 1);
        tick();
        chk("t3_pulse2", match_pulse, 1);
        chk("t3_popped", evt_valid, 0);
        tick();
        chk("t3_pulse3", match_pulse, 1);
        tick();
        chk("t3_pulse_end", match_pulse, 0);
        arm = 1'b0;

        // Six events with the consumer stalled: fill, drop, then drain
        evt_ready = 1'b0;
        do_reset();
        cnt_in = 4'd0;  tick();
        cnt_in = 4'd5;  tick();
        cnt_in = 4'd15; tick();
        cnt_in = 4'd0;  tick();
        cnt_in = 4'd8;  tick();
        chk("t4_not_full", fifo_full, 0);
        cnt_in = 4'd3;  tick();
        chk("t4_full", fifo_full, 1);
        chk("t4_no_ovf", overflow, 0);
        cnt_in = 4'd15; tick();
        chk("t4_ovf", overflow, 1);
        chk("t4_full_b", fifo_full, 1);
        tick();
        chk("t4_head0", evt_code, 2'b10);
        evt_ready = 1'b1;
        tick();
        chk("t4_head1", evt_code, 2'b10);
        chk("t4_unfull", fifo_full, 0);
        tick();
        chk("t4_head2", evt_code, 2'b00);
        tick();
        chk("t4_head3", evt_code, 2'b10);
        chk("t4_valid3", evt_valid, 1);
        tick();
        chk("t4_drained", evt_valid, 0);
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_wrap", wrap_cnt, 1);

        // Full FIFO with simultaneous push and pop
        evt_ready = 1'b0;
        do_reset();
        cnt_in = 4'd0;  tick();
        cnt_in = 4'd5;  tick();
        cnt_in = 4'd15; tick();
        cnt_in = 4'd0;  tick();
        cnt_in = 4'd8;  tick();
        cnt_in = 4'd3;  tick();
        chk("t5_full", fifo_full, 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("t5_still_full", fifo_full, 1);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_head0", evt_code, 2'b10);
        tick();
        chk("t5_stall_full", fifo_full, 1);
        evt_ready = 1'b1;
        tick();
        chk("t5_head1", evt_code, 2'b00);
        tick();
        chk("t5_head2", evt_code, 2'b10);
        tick();
        chk("t5_head3", evt_code, 2'b10);
        chk("t5_valid3", evt_valid, 1);
        tick();
        chk("t5_drained", evt_valid, 0);
        chk("t5_ovf_end", overflow, 0);

        // Reset during HOLD with two events queued
        evt_ready = 1'b0; arm = 1'b1; cmp_val = 4'd5;
        do_reset();
        cnt_in = 4'd3; tick();
        cnt_in = 4'd4; tick();
        cnt_in = 4'd5; tick();
        cnt_in = 4'd0; tick();
        tick();
        chk("t6_pulse", match_pulse, 1);
        chk("t6_valid", evt_valid, 1);
        chk("t6_head", evt_code, 2'b01);
        #2;
        rstn = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        cnt_in = 4'd9; arm = 1'b0; evt_ready = 1'b1;
        tick();
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_evt", evt_valid, 0);
        end
        chk("t6_no_pulse", match_pulse, 0);

        // Wrap tally saturation: alternate 15,0 for 300 wraps
        evt_ready = 1'b1; cnt_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cnt_in = i[0] ? 4'd0 : 4'd15;
            tick();
            if (i == 199) begin
                chk("t7_wrap_mid", wrap_cnt, 99);
            end
        end
        tick();
        chk("t7_wrap_sat", wrap_cnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
